// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, bit positions and byte-lane merge for pwm_seq_ctrl.
// Offsets are word indices taken from wbs_adr_i[7:2].
package pwm_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PERIOD   = 6'h01;
    localparam logic [5:0] OFF_PRESCALE = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_DUTY     = 6'h04;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_IRQ  = 1;
    localparam int CTRL_EN   = 8;
    localparam int STAT_PEND = 0;
    localparam int STAT_WRAP = 1;

    function automatic logic [31:0] wb_merge(
        input logic [31:0] old,
        input logic [31:0] din,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? din[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus period counter for the PWM datapath.
// Both counters are held at zero while run is low.
module pwm_timebase #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [15:0]   prescale,
    input  logic [CW-1:0] period,
    output logic [CW-1:0] cnt,
    output logic          tick,
    output logic          wrap
);

    logic [15:0] ps;

    assign tick = run && (ps == prescale);
    assign wrap = tick && (cnt == period);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            ps  <= '0;
            cnt <= '0;
        end else if (tick) begin
            ps  <= '0;
            cnt <= wrap ? '0 : cnt + CW'(1);
        end else begin
            ps <= ps + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: Wishbone register file with shadow/active period and duty.
// Optional wrap interrupt (irq_o, CTRL[1]) is built only with PWM_IRQ_EN.
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int          N_CH       = 4,
    parameter int          CW         = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [CW-1:0] DEF_PERIOD = {CW{1'b1}}
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [CW-1:0]    pwm_cnt_o,
    output logic [N_CH*CW-1:0] pwm_duty_o,
    output logic [N_CH-1:0]  pwm_en_o,
    output logic             pwm_upd_o
`ifdef PWM_IRQ_EN
    ,
    output logic             irq_o
`endif
);

    logic            hit, wr, load, tick, wrap;
    logic [5:0]      off;
    logic            wr_ctrl, wr_period, wr_presc, wr_status, w1c;
    logic            run, pend, wrap_st;
    logic [N_CH-1:0] en, en_q, is_duty, wr_duty;
    logic [CW-1:0]   period_sh, period_act, cnt;
    logic [15:0]     prescale;
    logic [CW-1:0]   duty_sh  [N_CH];
    logic [CW-1:0]   duty_act [N_CH];
    logic [CW-1:0]   duty_new [N_CH];
    logic [31:0]     ctrl_rd, period_rd, presc_rd, status_rd, duty_rd, rd_val;
    logic [31:0]     ctrl_m, period_m, presc_m, duty_m;
`ifdef PWM_IRQ_EN
    logic            irq_en;
`endif

    assign off       = wbs_adr_i[7:2];
    assign hit       = wbs_cyc_i && wbs_stb_i && !wbs_ack_o
                       && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr        = hit && wbs_we_i;
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_period = wr && (off == OFF_PERIOD);
    assign wr_presc  = wr && (off == OFF_PRESCALE);
    assign wr_status = wr && (off == OFF_STATUS);
    assign wr_duty   = is_duty & {N_CH{wr}};
    assign w1c       = wr_status && wbs_sel_i[0] && wbs_dat_i[STAT_WRAP];
    assign load      = wrap && pend;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_RUN] = run;
        ctrl_rd[CTRL_EN +: N_CH] = en;
`ifdef PWM_IRQ_EN
        ctrl_rd[CTRL_IRQ] = irq_en;
`endif
        period_rd = '0;
        period_rd[CW-1:0] = period_sh;
        presc_rd = '0;
        presc_rd[15:0] = prescale;
        status_rd = '0;
        status_rd[STAT_PEND] = pend;
        status_rd[STAT_WRAP] = wrap_st;
        ctrl_m   = wb_merge(ctrl_rd, wbs_dat_i, wbs_sel_i);
        period_m = wb_merge(period_rd, wbs_dat_i, wbs_sel_i);
        presc_m  = wb_merge(presc_rd, wbs_dat_i, wbs_sel_i);
        rd_val = '0;
        unique case (off)
            OFF_CTRL:     rd_val = ctrl_rd;
            OFF_PERIOD:   rd_val = period_rd;
            OFF_PRESCALE: rd_val = presc_rd;
            OFF_STATUS:   rd_val = status_rd;
            default:      rd_val = '0;
        endcase
        duty_rd = '0;
        duty_m  = '0;
        for (int i = 0; i < N_CH; i++) begin
            duty_rd = '0;
            duty_rd[CW-1:0] = duty_sh[i];
            duty_m = wb_merge(duty_rd, wbs_dat_i, wbs_sel_i);
            duty_new[i] = duty_m[CW-1:0];
            is_duty[i] = (off == OFF_DUTY + 6'(i));
            if (is_duty[i]) rd_val = duty_rd;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            run        <= 1'b0;
            en         <= '0;
            en_q       <= '0;
            period_sh  <= DEF_PERIOD;
            period_act <= DEF_PERIOD;
            prescale   <= '0;
            pend       <= 1'b0;
            wrap_st    <= 1'b0;
            pwm_upd_o  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
`ifdef PWM_IRQ_EN
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= hit;
            if (hit) wbs_dat_o <= rd_val;
            if (wr_ctrl) begin
                run <= ctrl_m[CTRL_RUN];
                en  <= ctrl_m[CTRL_EN +: N_CH];
`ifdef PWM_IRQ_EN
                irq_en <= ctrl_m[CTRL_IRQ];
`endif
            end
            if (wr_period) period_sh <= period_m[CW-1:0];
            if (wr_presc) prescale <= presc_m[15:0];
            for (int i = 0; i < N_CH; i++) begin
                if (wr_duty[i]) duty_sh[i] <= duty_new[i];
            end
            // Stopped: active tracks shadow; running: only at a pending wrap.
            if (!run || load) begin
                period_act <= period_sh;
                for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_sh[i];
            end
            pwm_upd_o <= load;
            if (!run) pend <= 1'b0;
            else if (wr_period || (|wr_duty)) pend <= 1'b1;
            else if (load) pend <= 1'b0;
            if (wrap) wrap_st <= 1'b1;
            else if (w1c) wrap_st <= 1'b0;
            en_q <= en & {N_CH{run}};
`ifdef PWM_IRQ_EN
            irq_o <= wrap_st && irq_en;
`endif
        end
    end

    pwm_timebase #(.CW(CW)) u_timebase (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .run      (run),
        .prescale (prescale),
        .period   (period_act),
        .cnt      (cnt),
        .tick     (tick),
        .wrap     (wrap)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_duty
        assign pwm_duty_o[g*CW +: CW] = duty_act[g];
    end

    assign pwm_cnt_o = cnt;
    assign pwm_en_o  = en_q;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], tick, ctrl_m, period_m, presc_m, duty_m};

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: directed register tables plus timed wrap/shadow sequences.
// Covers the PWM_IRQ_EN variant when that macro is defined.
module tb_pwm_seq_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PER  = BASE + 32'h04;
    localparam logic [31:0] A_PRE  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_DUTY = BASE + 32'h10;
    localparam logic [31:0] A_HOLE = BASE + 32'h3C;
`ifdef PWM_IRQ_EN
    localparam logic [31:0] IRQ_BIT = 32'h2;
`else
    localparam logic [31:0] IRQ_BIT = 32'h0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, upd;
    logic [3:0]  sel, en;
    logic [31:0] adr, dat, dat_o;
    logic [15:0] cnt;
    logic [63:0] duty;
`ifdef PWM_IRQ_EN
    logic        irq;
`endif
    logic        found, early, acked;
    logic [31:0] rd;
    int          total = 0;
    int          bad = 0;
    int          cnt_exp [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    vec_t        tbl [$];

    always #5 clk = ~clk;

    pwm_seq_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .pwm_cnt_o  (cnt),
        .pwm_duty_o (duty),
        .pwm_en_o   (en),
        .pwm_upd_o  (upd)
`ifdef PWM_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.wr = w; v.adr = a; v.dat = d; v.sel = s; v.exp = e;
        return v;
    endfunction

    // Caller is 1 ns after a posedge; returns 1 ns after the posedge following ack.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r, output logic ok);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk); #1;
        ok = ack;
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        if (ok) check("ack_width", {31'd0, ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic ok;
        xfer(1'b1, a, d, s, r, ok);
        check($sformatf("wr_ack_%h", a), {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string name);
        logic [31:0] r;
        logic ok;
        xfer(1'b0, a, 32'd0, 4'hF, r, ok);
        check({name, "_ack"}, {31'd0, ok}, 32'd1);
        check(name, r, e);
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            if (tbl[i].wr) wb_write(tbl[i].adr, tbl[i].dat, tbl[i].sel);
            wb_read(tbl[i].adr, tbl[i].exp, $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic load_reset_tbl();
        tbl.delete();
        tbl.push_back(mk(1'b0, A_CTRL, 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, A_PER,  0, 0, 32'hFFFF));
        tbl.push_back(mk(1'b0, A_PRE,  0, 0, 32'h0));
        tbl.push_back(mk(1'b0, A_STAT, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, A_DUTY + 32'(4*i), 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, A_HOLE, 0, 0, 32'h0));
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int bound, input string name);
        logic f;
        f = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (cnt == v) begin f = 1'b1; break; end
            @(posedge clk); #1;
        end
        check(name, {31'd0, f}, 32'd1);
    endtask

    task automatic wait_upd(input int bound, input string name);
        logic f;
        f = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (upd) begin f = 1'b1; break; end
            @(posedge clk); #1;
        end
        check(name, {31'd0, f}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", {16'd0, cnt}, 0);
        check("rst_ack", {31'd0, ack}, 0);
        check("rst_dat", dat_o, 0);
        check("rst_duty_lo", duty[31:0], 0);
        check("rst_duty_hi", duty[63:32], 0);
        check("rst_en", {28'd0, en}, 0);
        check("rst_upd", {31'd0, upd}, 0);
`ifdef PWM_IRQ_EN
        check("rst_irq", {31'd0, irq}, 0);
`endif
        rst = 1'b0;
        load_reset_tbl();
        run_tbl("reset_rd");

        // Timebase: PRESCALE=1, PERIOD=3, then RUN with all EN
        wb_write(A_PRE, 32'd1, 4'hF);
        wb_write(A_PER, 32'd3, 4'hF);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; dat = 32'h0F01; sel = 4'hF;
        @(posedge clk); #1;
        check("run_ack", {31'd0, ack}, 1);
        check("cnt_seq[0]", {16'd0, cnt}, 32'(cnt_exp[0]));
        check("en_in_ack", {28'd0, en}, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int k = 1; k < 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("cnt_seq[%0d]", k), {16'd0, cnt}, 32'(cnt_exp[k]));
            if (k == 1) check("en_after_ack", {28'd0, en}, 32'hF);
        end
        wb_read(A_STAT, 32'h2, "wrap_set");

        // Shadow update mid-period, PRESCALE=0, PERIOD=15
        wb_write(A_CTRL, 32'h0, 4'hF);
        wb_write(A_STAT, 32'h2, 4'hF);
        wb_write(A_PRE, 32'd0, 4'hF);
        wb_write(A_PER, 32'd15, 4'hF);
        wb_write(A_CTRL, 32'h0F01, 4'hF);
        wait_cnt(16'd2, 40, "reach_cnt2");
        wb_write(A_DUTY, 32'd2, 4'hF);
        check("duty0_held", {16'd0, duty[15:0]}, 0);
        wb_read(A_STAT, 32'h1, "pend_set");
        found = 1'b0; early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (upd) begin found = 1'b1; break; end
            if (duty[15:0] !== 16'd0) early = 1'b1;
            @(posedge clk); #1;
        end
        check("upd_seen", {31'd0, found}, 1);
        check("duty0_early", {31'd0, early}, 0);
        check("duty0_loaded", {16'd0, duty[15:0]}, 32'd2);
        wb_read(A_STAT, 32'h2, "pend_clear");

        // Write landing on the wrap edge
        wb_write(A_DUTY + 32'h4, 32'd9, 4'hF);
        wait_cnt(16'd15, 40, "reach_wrap");
        wb_write(A_DUTY + 32'h4, 32'd7, 4'hF);
        check("duty1_old", {16'd0, duty[31:16]}, 32'd9);
        wb_read(A_STAT, 32'h3, "pend_kept");
        wait_upd(40, "upd2_seen");
        check("duty1_new", {16'd0, duty[31:16]}, 32'd7);
        check("duty0_keep", {16'd0, duty[15:0]}, 32'd2);

        // Byte lanes, hole, W1C, pass-through duty, off-window
        wb_write(A_CTRL, 32'h0, 4'hF);
        tbl.delete();
        tbl.push_back(mk(1'b1, A_PER, 32'h0000_FFFF, 4'hF, 32'hFFFF));
        tbl.push_back(mk(1'b1, A_PER, 32'h1234_5678, 4'h1, 32'hFF78));
        tbl.push_back(mk(1'b1, A_PRE, 32'h0000_ABCD, 4'h2, 32'hAB00));
        tbl.push_back(mk(1'b1, A_CTRL, 32'hFFFF_FFFF, 4'h2, 32'h0F00));
        tbl.push_back(mk(1'b1, A_CTRL, 32'h0000_0002, 4'h1, 32'h0F00 | IRQ_BIT));
        tbl.push_back(mk(1'b1, A_STAT, 32'hFFFF_FFFF, 4'hF, 32'h0));
        tbl.push_back(mk(1'b1, A_DUTY + 32'h8, 32'h0000_FFFF, 4'hF, 32'hFFFF));
        tbl.push_back(mk(1'b1, A_DUTY + 32'hC, 32'hFFFF_1234, 4'h3, 32'h1234));
        tbl.push_back(mk(1'b1, A_HOLE, 32'hFFFF_FFFF, 4'hF, 32'h0));
        run_tbl("cfg");
        check("duty2_pass", {16'd0, duty[47:32]}, 32'hFFFF);
        check("duty3_copy", {16'd0, duty[63:48]}, 32'h1234);
        xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, rd, acked);
        check("offwin_rd", {31'd0, acked}, 0);
        xfer(1'b1, 32'h2000_0004, 32'd0, 4'hF, rd, acked);
        check("offwin_wr", {31'd0, acked}, 0);
        wb_read(A_PER, 32'hFF78, "per_kept");

`ifdef PWM_IRQ_EN
        wb_write(A_PRE, 32'd0, 4'hF);
        wb_write(A_PER, 32'd3, 4'hF);
        wb_write(A_CTRL, 32'h0F03, 4'hF);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (irq) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("irq_set", {31'd0, found}, 1);
        wb_write(A_CTRL, 32'h0F02, 4'hF);
        wb_write(A_STAT, 32'h2, 4'hF);
        @(posedge clk); #1;
        check("irq_clear", {31'd0, irq}, 0);
`endif

        // Reset mid-count and mid-transfer
        wb_write(A_PRE, 32'd0, 4'hF);
        wb_write(A_PER, 32'd15, 4'hF);
        wb_write(A_DUTY, 32'd5, 4'hF);
        wb_write(A_CTRL, 32'h0F01, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("cnt_running", {31'd0, cnt != 16'd0}, 1);
        check("duty0_pre_rst", {16'd0, duty[15:0]}, 32'd5);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_PER;
        @(posedge clk); #1;
        check("mid_rst_ack", {31'd0, ack}, 0);
        check("mid_rst_cnt", {16'd0, cnt}, 0);
        check("mid_rst_duty", duty[31:0], 0);
        check("mid_rst_en", {28'd0, en}, 0);
        check("mid_rst_upd", {31'd0, upd}, 0);
`ifdef PWM_IRQ_EN
        check("mid_rst_irq", {31'd0, irq}, 0);
`endif
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack", {31'd0, ack}, 0);
        load_reset_tbl();
        run_tbl("rst2_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
